mio_bus_arbiter: RTL and testbench

Two-master arbiter that shares the single data-memory/MIO port between the multicycle CPU (master 0, driven by the MCtrl-sequenced datapath) and a DMA/debug loader (master 1). It serialises accesses, drives the memory-side strobes, and returns a one-cycle ready pulse that feeds the CPU's `MIO_ready` input. It sits between the CPU/loader and the block RAM / peripheral bus.

---
 rtl/mio_arb_pkg.sv | 20 ++
 rtl/mio_arb_pick.sv | 37 +++
 rtl/mio_bus_arbiter.sv | 131 +++++++++++++
 tb/tb_mio_bus_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mio_arb_pkg.sv
// rtl/mio_arb_pkg.sv - shared state encoding, master indices and latency limits for mio_bus_arbiter
package mio_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_e;

    // Master indices as carried by the winner / pointer bits
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // Legal memory latency range; the wait counter is sized for the maximum
    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 4;
    localparam int CNT_W       = 2;

endpackage

// File: rtl/mio_arb_pick.sv
// rtl/mio_arb_pick.sv - combinational winner selection; MIO_ARB_RR_EN selects round-robin over fixed priority
module mio_arb_pick
    import mio_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic any,
    output logic win
);

    assign any = req0 | req1;

`ifdef MIO_ARB_RR_EN
    // On a tie the master that did not win last time goes next
    always_comb begin
        win = M0;
        if (req0 && req1) begin
            win = ~last;
        end else if (req1) begin
            win = M1;
        end
    end
`else
    // CPU always wins ties; the pointer is not consulted in this mode
    logic unused_ptr;
    assign unused_ptr = last;

    always_comb begin
        win = M0;
        if (!req0 && req1) begin
            win = M1;
        end
    end
`endif

endmodule

// File: rtl/mio_bus_arbiter.sv
// rtl/mio_bus_arbiter.sv - two-master MIO port arbiter (IDLE/ACCESS/WAIT/DONE), tie-break set by MIO_ARB_RR_EN
module mio_bus_arbiter
    import mio_arb_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ready,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        grant,
    output logic [1:0]        arb_state
);

    if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
        $error("mio_bus_arbiter: MEM_LAT out of range");
    end

    arb_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             cur_win;
    logic             cur_we;
    logic             rr_last;
    logic             pick_any;
    logic             pick_win;

    mio_arb_pick u_pick (
        .req0 (m0_req),
        .req1 (m1_req),
        .last (rr_last),
        .any  (pick_any),
        .win  (pick_win)
    );

    assign arb_state = state;

    // Transaction sequencer; every output is a register written here
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cur_win   <= M0;
            cur_we    <= 1'b0;
            rr_last   <= M1;
            grant     <= 2'b00;
            m0_ready  <= 1'b0;
            m1_ready  <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        state   <= ST_ACCESS;
                        cur_win <= pick_win;
                        rr_last <= pick_win;
                        grant   <= (pick_win == M1) ? 2'b10 : 2'b01;
                        mem_en  <= 1'b1;
                        if (pick_win == M1) begin
                            cur_we    <= m1_we;
                            mem_we    <= m1_we;
                            mem_addr  <= m1_addr;
                            mem_wdata <= m1_wdata;
                        end else begin
                            cur_we    <= m0_we;
                            mem_we    <= m0_we;
                            mem_addr  <= m0_addr;
                            mem_wdata <= m0_wdata;
                        end
                    end
                end
                ST_ACCESS: begin
                    state     <= ST_WAIT;
                    cnt       <= CNT_W'(MEM_LAT - 1);
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state    <= ST_DONE;
                        m0_ready <= (cur_win == M0);
                        m1_ready <= (cur_win == M1);
                        // Writes share the same timing but leave read data alone
                        if (!cur_we) begin
                            if (cur_win == M1) begin
                                m1_rdata <= mem_rdata;
                            end else begin
                                m0_rdata <= mem_rdata;
                            end
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    grant    <= 2'b00;
                    m0_ready <= 1'b0;
                    m1_ready <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// tb/tb_mio_bus_arbiter.sv - directed self-checking bench for mio_bus_arbiter at MEM_LAT 1 and 3
module tb_mio_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    int          n_tests = 0;
    int          n_fail = 0;

    // Instance A: MEM_LAT = 1, both masters driven
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, mem_rdata;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_mem_addr, a_mem_wdata;
    logic        a_m0_ready, a_m1_ready, a_mem_en, a_mem_we;
    logic [1:0]  a_grant, a_state;

    // Instance B: MEM_LAT = 3, only master 0 driven
    logic        b_m0_req, b_m0_we;
    logic [31:0] b_m0_addr, b_m0_wdata, b_mem_rdata;
    logic        b_m1_req, b_m1_we;
    logic [31:0] b_m1_addr, b_m1_wdata;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_wdata;
    logic        b_m0_ready, b_m1_ready, b_mem_en, b_mem_we;
    logic [1:0]  b_grant, b_state;

    logic [1:0]  exp_grant [3];

    always #5 clk = ~clk;

    mio_bus_arbiter #(.MEM_LAT(1), .ADDR_W(32), .DATA_W(32)) dut_a (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(a_m0_rdata), .m0_ready(a_m0_ready),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(a_m1_rdata), .m1_ready(a_m1_ready),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata),
        .grant(a_grant), .arb_state(a_state)
    );

    mio_bus_arbiter #(.MEM_LAT(3), .ADDR_W(32), .DATA_W(32)) dut_b (
        .clk(clk), .reset(reset),
        .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
        .m0_rdata(b_m0_rdata), .m0_ready(b_m0_ready),
        .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
        .m1_rdata(b_m1_rdata), .m1_ready(b_m1_ready),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .grant(b_grant), .arb_state(b_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef MIO_ARB_RR_EN
        exp_grant[0] = 2'b01; exp_grant[1] = 2'b10; exp_grant[2] = 2'b01;
`else
        exp_grant[0] = 2'b01; exp_grant[1] = 2'b01; exp_grant[2] = 2'b01;
`endif
        reset = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
        mem_rdata = 32'h0;
        b_m0_req = 1'b1; b_m0_we = 1'b0; b_m0_addr = 32'h0; b_m0_wdata = 32'h0;
        b_m1_req = 1'b0; b_m1_we = 1'b0; b_m1_addr = 32'h0; b_m1_wdata = 32'h0;
        b_mem_rdata = 32'h0;

        // Reset held with requests high
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_state", a_state, 2'd0);
            chk("rst_grant", a_grant, 2'b00);
            chk("rst_mem_en", a_mem_en, 1'b0);
            chk("rst_ready", {a_m0_ready, a_m1_ready}, 2'b00);
        end
        chk("rst_mem_addr", a_mem_addr, 32'h0);
        chk("rst_m0_rdata", a_m0_rdata, 32'h0);
        chk("rst_b_mem_en", b_mem_en, 1'b0);

        m0_req = 1'b0; m1_req = 1'b0; b_m0_req = 1'b0;
        reset = 1'b0;
        step();
        chk("idle_state", a_state, 2'd0);

        // m0 read 0x10, MEM_LAT=1
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10; mem_rdata = 32'hDEADBEEF;
        step();
        chk("rd_c1_mem_en", a_mem_en, 1'b1);
        chk("rd_c1_mem_we", a_mem_we, 1'b0);
        chk("rd_c1_addr", a_mem_addr, 32'h10);
        chk("rd_c1_grant", a_grant, 2'b01);
        chk("rd_c1_state", a_state, 2'd1);
        step();
        chk("rd_c2_state", a_state, 2'd2);
        chk("rd_c2_mem_en", a_mem_en, 1'b0);
        chk("rd_c2_addr", a_mem_addr, 32'h0);
        chk("rd_c2_ready", a_m0_ready, 1'b0);
        step();
        chk("rd_c3_ready", a_m0_ready, 1'b1);
        chk("rd_c3_m1_ready", a_m1_ready, 1'b0);
        chk("rd_c3_rdata", a_m0_rdata, 32'hDEADBEEF);
        chk("rd_c3_grant", a_grant, 2'b01);
        chk("rd_c3_state", a_state, 2'd3);
        m0_req = 1'b0;
        step();
        chk("rd_c4_ready", a_m0_ready, 1'b0);
        chk("rd_c4_grant", a_grant, 2'b00);
        chk("rd_c4_state", a_state, 2'd0);

        // m1 write 0x20 <- 0x12345678; read data on the bus must not be captured
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h12345678;
        mem_rdata = 32'hBAD0BAD0;
        step();
        chk("wr_c1_mem_en", a_mem_en, 1'b1);
        chk("wr_c1_mem_we", a_mem_we, 1'b1);
        chk("wr_c1_addr", a_mem_addr, 32'h20);
        chk("wr_c1_wdata", a_mem_wdata, 32'h12345678);
        chk("wr_c1_grant", a_grant, 2'b10);
        step();
        chk("wr_c2_mem_we", a_mem_we, 1'b0);
        chk("wr_c2_wdata", a_mem_wdata, 32'h0);
        step();
        chk("wr_c3_m1_ready", a_m1_ready, 1'b1);
        chk("wr_c3_m0_ready", a_m0_ready, 1'b0);
        chk("wr_c3_m1_rdata", a_m1_rdata, 32'h0);
        chk("wr_c3_m0_rdata", a_m0_rdata, 32'hDEADBEEF);
        m1_req = 1'b0; m1_we = 1'b0;
        step();
        chk("wr_c4_m1_ready", a_m1_ready, 1'b0);

        // Both request continuously for three rounds
        m0_req = 1'b1; m0_addr = 32'h30;
        m1_req = 1'b1; m1_addr = 32'h40;
        mem_rdata = 32'h0000A5A5;
        for (int r = 0; r < 3; r++) begin
            step();
            chk("tie_grant", a_grant, exp_grant[r]);
            chk("tie_addr", a_mem_addr, (exp_grant[r] == 2'b10) ? 32'h40 : 32'h30);
            step();
            step();
            chk("tie_ready", {a_m1_ready, a_m0_ready}, exp_grant[r]);
            step();
            chk("tie_turnaround_state", a_state, 2'd0);
            chk("tie_turnaround_en", a_mem_en, 1'b0);
        end

        // Pending m1 gets the bus once m0 lets go
        m0_req = 1'b0;
        step();
        chk("pend_grant", a_grant, 2'b10);
        step();
        step();
        chk("pend_m1_ready", a_m1_ready, 1'b1);
        chk("pend_m1_rdata", a_m1_rdata, 32'h0000A5A5);
        m1_req = 1'b0;
        step();
        step();
        chk("pend_idle", a_state, 2'd0);

        // MEM_LAT=3: reset in WAIT, then a clean read with req dropped mid-WAIT
        b_m0_req = 1'b1; b_m0_addr = 32'h50; b_mem_rdata = 32'hCAFEF00D;
        step();
        chk("b_c1_mem_en", b_mem_en, 1'b1);
        step();
        chk("b_c2_state", b_state, 2'd2);
        step();
        chk("b_c3_state", b_state, 2'd2);
        reset = 1'b1;
        step();
        chk("b_rst_state", b_state, 2'd0);
        chk("b_rst_ready", b_m0_ready, 1'b0);
        chk("b_rst_grant", b_grant, 2'b00);
        reset = 1'b0;
        step();
        chk("b2_c1_mem_en", b_mem_en, 1'b1);
        chk("b2_c1_addr", b_mem_addr, 32'h50);
        step();
        step();
        b_m0_req = 1'b0;
        chk("b2_c3_state", b_state, 2'd2);
        step();
        chk("b2_c4_state", b_state, 2'd2);
        chk("b2_c4_ready", b_m0_ready, 1'b0);
        step();
        chk("b2_c5_ready", b_m0_ready, 1'b1);
        chk("b2_c5_rdata", b_m0_rdata, 32'hCAFEF00D);
        chk("b2_c5_state", b_state, 2'd3);
        step();
        chk("b2_c6_ready", b_m0_ready, 1'b0);
        chk("b2_c6_state", b_state, 2'd0);
        step();
        chk("b2_c7_state", b_state, 2'd0);
        chk("b2_c7_m1_ready", b_m1_ready, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
